// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared opcodes, state encoding and key indices for the tetris command scheduler
package tetris_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_DOWN   = 3'd1;
  localparam logic [2:0] OP_LEFT   = 3'd2;
  localparam logic [2:0] OP_RIGHT  = 3'd3;
  localparam logic [2:0] OP_ROTATE = 3'd4;
  localparam logic [2:0] OP_SPAWN  = 3'd5;

  typedef enum logic [1:0] {
    S_PICK  = 2'd0,
    S_OFFER = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam int KEY_LEFT   = 0;
  localparam int KEY_RIGHT  = 1;
  localparam int KEY_ROTATE = 2;
  localparam int KEY_DROP   = 3;

  // A drop request is just a player-initiated DOWN.
  function automatic logic [2:0] key_opcode(input logic [1:0] idx);
    case (idx)
      2'(KEY_LEFT):   return OP_LEFT;
      2'(KEY_RIGHT):  return OP_RIGHT;
      2'(KEY_ROTATE): return OP_ROTATE;
      default:        return OP_DOWN;
    endcase
  endfunction

endpackage

// File: rtl/tetris_cmd_sched_if.sv
// rtl/tetris_cmd_sched_if.sv - instruction issue handshake and retire feedback between scheduler and pipeline
interface tetris_cmd_sched_if #(
  parameter int WIDTH = 8
);
  logic [2*WIDTH-1:0] instr_out;
  logic               instr_valid;
  logic               instr_ready;
  logic               done;
  logic               touch;

  modport master (
    output instr_out,
    output instr_valid,
    input  instr_ready,
    input  done,
    input  touch
  );

  modport slave (
    input  instr_out,
    input  instr_valid,
    output instr_ready,
    output done,
    output touch
  );
endinterface

// File: rtl/tetris_rr_arb.sv
// rtl/tetris_rr_arb.sv - combinational 4-way round-robin arbiter; pointer is owned by the caller
module tetris_rr_arb (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_vld
);

  // Scan from the farthest offset down so the request nearest the pointer wins.
  always_comb begin
    grant_idx = ptr;
    grant_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        grant_idx = ptr + 2'(k);
        grant_vld = 1'b1;
      end
    end
    grant = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
  end

endmodule

// File: rtl/tetris_cmd_sched.sv
// rtl/tetris_cmd_sched.sv - issues one spawn/gravity/key instruction at a time and reacts to the retire result
module tetris_cmd_sched
  import tetris_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TICK_PERIOD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         key_req,
  output logic [3:0]         key_ack,
  input  logic [WIDTH-1:0]   spawn_shape,
  output logic               halted,
  tetris_cmd_sched_if.master bus
);

  localparam int CW = $clog2(TICK_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_PERIOD - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               grav_q, grav_d;
  logic               spawn_q, spawn_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [2*WIDTH-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [3:0]         ack_q, ack_d;
  logic               halted_q, halted_d;
  logic               from_key_q, from_key_d;
  logic [1:0]         kidx_q, kidx_d;
  logic [3:0]         kgrant_q, kgrant_d;
  logic [2:0]         issued_q, issued_d;

  logic [3:0] arb_grant;
  logic [1:0] arb_idx;
  logic       arb_vld;
  logic       accept;
  logic       wrap;

  tetris_rr_arb u_arb (
    .req       (key_req),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  assign accept = valid_q && bus.instr_ready;
  assign wrap   = (state_q != S_HALT) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grav_d     = grav_q;
    spawn_d    = spawn_q;
    ptr_d      = ptr_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    ack_d      = 4'b0000;
    halted_d   = halted_q;
    from_key_d = from_key_q;
    kidx_d     = kidx_q;
    kgrant_d   = kgrant_q;
    issued_d   = issued_q;

    if (state_q != S_HALT) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end

    // Clear-on-DOWN comes first so a coincident wrap re-arms gravity.
    if (accept && (instr_q[2*WIDTH-1:WIDTH] == WIDTH'(OP_DOWN))) begin
      grav_d = 1'b0;
    end
    if (wrap) begin
      grav_d = 1'b1;
    end

    case (state_q)
      S_PICK: begin
        if (spawn_q) begin
          instr_d    = {WIDTH'(OP_SPAWN), spawn_shape};
          from_key_d = 1'b0;
          valid_d    = 1'b1;
          state_d    = S_OFFER;
        end else if (grav_q) begin
          instr_d    = {WIDTH'(OP_DOWN), {WIDTH{1'b0}}};
          from_key_d = 1'b0;
          valid_d    = 1'b1;
          state_d    = S_OFFER;
        end else if (arb_vld) begin
          instr_d    = {WIDTH'(key_opcode(arb_idx)), {WIDTH{1'b0}}};
          from_key_d = 1'b1;
          kidx_d     = arb_idx;
          kgrant_d   = arb_grant;
          valid_d    = 1'b1;
          state_d    = S_OFFER;
        end
      end
      S_OFFER: begin
        if (accept) begin
          valid_d  = 1'b0;
          issued_d = instr_q[WIDTH+2:WIDTH];
          state_d  = S_WAIT;
          if (from_key_q) begin
            ack_d = kgrant_q;
            ptr_d = kidx_q + 2'd1;
          end
        end
      end
      S_WAIT: begin
        if (bus.done) begin
          state_d = S_PICK;
          if (issued_q == OP_SPAWN) begin
            if (bus.touch) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              spawn_d = 1'b0;
            end
          end else if ((issued_q == OP_DOWN) && bus.touch) begin
            spawn_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_PICK;
      cnt_q      <= '0;
      grav_q     <= 1'b0;
      spawn_q    <= 1'b1;
      ptr_q      <= 2'd0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 4'b0000;
      halted_q   <= 1'b0;
      from_key_q <= 1'b0;
      kidx_q     <= 2'd0;
      kgrant_q   <= 4'b0000;
      issued_q   <= OP_NOP;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grav_q     <= grav_d;
      spawn_q    <= spawn_d;
      ptr_q      <= ptr_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      halted_q   <= halted_d;
      from_key_q <= from_key_d;
      kidx_q     <= kidx_d;
      kgrant_q   <= kgrant_d;
      issued_q   <= issued_d;
    end
  end

  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign key_ack         = ack_q;
  assign halted          = halted_q;

endmodule
